// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the memory arbiter slice.
//   arb_state_t    - arbiter FSM states (IDLE, BUSY, DONE)
//   arb_owner_t    - which core port owns the current memory access
//   ARB_ABORT_DATA - read data returned when the watchdog aborts an access
//   ARB_ADDR_W / ARB_DATA_W - default address and data widths
package mips_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    localparam logic [31:0] ARB_ABORT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// arb_select: combinational grant decision between fetch and data ports.
// Optional build macro: MEM_ARBITER_RR_EN (round-robin on collisions).
// Ports:
//   i_req, d_req  - pending fetch / data requests
//   last_owner    - port served by the previous grant (used only with RR)
//   grant         - at least one request is pending
//   owner         - port selected for the next access
module arb_select
    import mips_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  arb_owner_t last_owner,
    output logic       grant,
    output arb_owner_t owner
);

`ifdef MEM_ARBITER_RR_EN
    // Collision: serve the port that was not served last; otherwise whoever asks.
    always_comb begin
        grant = i_req | d_req;
        owner = OWN_DATA;
        if (i_req && d_req) begin
            if (last_owner == OWN_DATA) begin
                owner = OWN_INSTR;
            end else begin
                owner = OWN_DATA;
            end
        end else if (d_req) begin
            owner = OWN_DATA;
        end else if (i_req) begin
            owner = OWN_INSTR;
        end else begin
            owner = OWN_DATA;
        end
    end
`else
    // History is irrelevant with fixed priority.
    logic unused_last_owner_s;
    assign unused_last_owner_s = last_owner;

    // Fixed priority: data always beats fetch.
    always_comb begin
        grant = i_req | d_req;
        owner = OWN_DATA;
        if (d_req) begin
            owner = OWN_DATA;
        end else if (i_req) begin
            owner = OWN_INSTR;
        end else begin
            owner = OWN_DATA;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the core's instruction
// fetch port and data load/store port. Requests are serialized through an
// IDLE -> BUSY -> DONE FSM; the DONE cycle carries a one-cycle ack pulse.
// Optional build macro: MEM_ARBITER_RR_EN (round-robin arbitration instead
// of fixed data-over-fetch priority).
// Ports:
//   clock, reset                    - clock, synchronous active-high reset
//   i_req/i_addr/i_rdata/i_ack/i_stall           - fetch port
//   d_req/d_we/d_addr/d_wdata/d_rdata/d_ack/d_stall - data port
//   err                             - pulses with the ack of an aborted access
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready - memory side
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int DATA_W  = ARB_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_stall,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [DATA_W-1:0] ABORT_C   = DATA_W'(ARB_ABORT_DATA);

    arb_state_t       state_r;
    arb_state_t       state_nxt_s;
    arb_owner_t       owner_r;
    arb_owner_t       sel_owner_s;
    arb_owner_t       last_owner_s;
    logic [CNT_W-1:0] cnt_r;
    logic             grant_s;
    logic             ready_s;
    logic             timeout_s;
    logic             issue_s;
    logic             finish_s;
    logic             abort_s;

    assign i_stall   = i_req & ~i_ack;
    assign d_stall   = d_req & ~d_ack;
    assign ready_s   = mem_req & mem_ready;
    assign timeout_s = (TIMEOUT != 0) && (cnt_r == TIMEOUT_C);

    arb_select u_arb_select (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_owner (last_owner_s),
        .grant      (grant_s),
        .owner      (sel_owner_s)
    );

`ifdef MEM_ARBITER_RR_EN
    arb_owner_t last_owner_r;

    // Remember the most recently granted port so collisions alternate.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_owner_r <= OWN_INSTR;
        end else if (issue_s) begin
            last_owner_r <= sel_owner_s;
        end else begin
            last_owner_r <= last_owner_r;
        end
    end

    assign last_owner_s = last_owner_r;
`else
    assign last_owner_s = OWN_INSTR;
`endif

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: DONE never grants, so a req held through the ack is not re-issued.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (ready_s || timeout_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Per-state control strobes; a ready in the timeout cycle wins over abort.
    always_comb begin
        issue_s  = 1'b0;
        finish_s = 1'b0;
        abort_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
            end
            BUSY: begin
                if (ready_s) begin
                    finish_s = 1'b1;
                end else if (timeout_s) begin
                    abort_s = 1'b1;
                end else begin
                    finish_s = 1'b0;
                end
            end
            default: begin
                issue_s = 1'b0;
            end
        endcase
    end

    // Registered memory request, latched fields, wait counter, acks and read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
            owner_r   <= OWN_DATA;
            cnt_r     <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            err   <= 1'b0;
            if (issue_s) begin
                mem_req <= 1'b1;
                owner_r <= sel_owner_s;
                cnt_r   <= '0;
                if (sel_owner_s == OWN_DATA) begin
                    mem_we    <= d_we;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end else begin
                    mem_we    <= 1'b0;
                    mem_addr  <= i_addr;
                    mem_wdata <= '0;
                end
            end else if (finish_s || abort_s) begin
                mem_req <= 1'b0;
                err     <= abort_s;
                if (owner_r == OWN_DATA) begin
                    d_ack <= 1'b1;
                    if (abort_s) begin
                        d_rdata <= ABORT_C;
                    end else if (mem_we) begin
                        d_rdata <= '0;
                    end else begin
                        d_rdata <= mem_rdata;
                    end
                end else begin
                    i_ack <= 1'b1;
                    if (abort_s) begin
                        i_rdata <= ABORT_C;
                    end else begin
                        i_rdata <= mem_rdata;
                    end
                end
            end else if (state_r == BUSY) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (TIMEOUT=4).
// A small memory responder answers after wait_cfg wait states, or never
// while hang is set.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        i_stall;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_stall;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int          total = 0;
    int          bad = 0;
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    int          n_access = 0;
    logic        hang = 1'b0;
    logic [31:0] rdata_cfg = 32'h0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ack     (i_ack),
        .i_stall   (i_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .d_stall   (d_stall),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clock = ~clock;

    // Memory responder: ready after wait_cfg cycles of mem_req.
    assign mem_ready = mem_req && !hang && (wait_cnt == wait_cfg);
    assign mem_rdata = mem_ready ? rdata_cfg : 32'h0;

    always @(posedge clock) begin
        if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (mem_req && mem_ready) n_access <= n_access + 1;
    end

    task automatic test_reset();
        repeat (2) @(negedge clock);
        total++;
        if ({mem_req, mem_we, i_ack, d_ack, err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, i_ack, d_ack, err});
        end
        total++;
        if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'h0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, i_rdata, d_rdata});
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch_alone();
        wait_cfg = 0; hang = 1'b0; rdata_cfg = 32'h1C010005;
        @(negedge clock);                 // cycle 0
        i_req = 1'b1; i_addr = 32'h0;
        #1;
        total++;
        if ({i_stall, mem_req} !== 2'b10) begin
            bad++; $display("FAIL fetch_c0: got stall,mreq=%b want 10", {i_stall, mem_req});
        end
        @(negedge clock);                 // cycle 1
        total++;
        if ({mem_req, mem_we, i_ack, i_stall} !== 4'b1001 || mem_addr !== 32'h0) begin
            bad++; $display("FAIL fetch_c1: got req,we,ack,stall=%b addr=%h want 1001 0", {mem_req, mem_we, i_ack, i_stall}, mem_addr);
        end
        @(negedge clock);                 // cycle 2
        total++;
        if ({i_ack, i_stall, mem_req} !== 3'b100 || i_rdata !== 32'h1C010005) begin
            bad++; $display("FAIL fetch_c2: got ack,stall,mreq=%b rdata=%h want 100 1c010005", {i_ack, i_stall, mem_req}, i_rdata);
        end
        i_req = 1'b0;
        @(negedge clock);                 // cycle 3
        total++;
        if ({i_ack, mem_req} !== 2'b00) begin
            bad++; $display("FAIL fetch_c3: got ack,mreq=%b want 00", {i_ack, mem_req});
        end
    endtask

    task automatic test_store_wait();
        wait_cfg = 3; rdata_cfg = 32'h55;
        @(negedge clock);                 // cycle 0
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hB;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            total++;
            if ({mem_req, mem_we, d_ack} !== 3'b110 || mem_addr !== 32'h20 || mem_wdata !== 32'hB) begin
                bad++; $display("FAIL store_hold c%0d: got req,we,ack=%b addr=%h wdata=%h want 110 20 b", c, {mem_req, mem_we, d_ack}, mem_addr, mem_wdata);
            end
        end
        @(negedge clock);                 // cycle 5
        total++;
        if ({d_ack, err, mem_req, d_stall} !== 4'b1000 || d_rdata !== 32'h0) begin
            bad++; $display("FAIL store_ack: got ack,err,mreq,stall=%b rdata=%h want 1000 0", {d_ack, err, mem_req, d_stall}, d_rdata);
        end
        d_req = 1'b0; d_we = 1'b0; wait_cfg = 0;
        @(negedge clock);
        total++;
        if (d_ack !== 1'b0) begin
            bad++; $display("FAIL store_pulse: got ack=%b want 0", d_ack);
        end
    endtask

    task automatic test_collision();
        logic first_data;
`ifdef MEM_ARBITER_RR_EN
        first_data = 1'b0;
`else
        first_data = 1'b1;
`endif
        rdata_cfg = first_data ? 32'h6 : 32'h77;
        @(negedge clock);                 // cycle 0
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        @(negedge clock);                 // cycle 1
        total++;
        if (mem_req !== 1'b1 || mem_addr !== (first_data ? 32'h100 : 32'h40)) begin
            bad++; $display("FAIL coll_first_addr: got req=%b addr=%h want 1 %h", mem_req, mem_addr, first_data ? 32'h100 : 32'h40);
        end
        @(negedge clock);                 // cycle 2
        total++;
        if (first_data ? ({d_ack, i_ack} !== 2'b10 || d_rdata !== 32'h6)
                       : ({i_ack, d_ack} !== 2'b10 || i_rdata !== 32'h77)) begin
            bad++; $display("FAIL coll_first_ack: got d_ack=%b i_ack=%b d_rdata=%h i_rdata=%h", d_ack, i_ack, d_rdata, i_rdata);
        end
        if (first_data) d_req = 1'b0; else i_req = 1'b0;
        rdata_cfg = first_data ? 32'h77 : 32'h6;
        @(negedge clock);                 // cycle 3: IDLE, no access yet
        total++;
        if (mem_req !== 1'b0) begin
            bad++; $display("FAIL coll_gap: got mreq=%b want 0", mem_req);
        end
        @(negedge clock);                 // cycle 4
        total++;
        if (mem_req !== 1'b1 || mem_addr !== (first_data ? 32'h40 : 32'h100)) begin
            bad++; $display("FAIL coll_second_addr: got req=%b addr=%h want 1 %h", mem_req, mem_addr, first_data ? 32'h40 : 32'h100);
        end
        @(negedge clock);                 // cycle 5
        total++;
        if ((first_data ? i_ack : d_ack) !== 1'b1 || i_rdata !== 32'h77 || d_rdata !== 32'h6) begin
            bad++; $display("FAIL coll_second_ack: got i_ack=%b d_ack=%b i_rdata=%h d_rdata=%h want second ack, 77, 6", i_ack, d_ack, i_rdata, d_rdata);
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_held_req();
        int base;
        wait_cfg = 0; rdata_cfg = 32'h1234;
        @(negedge clock);                 // cycle 0
        base = n_access;
        i_req = 1'b1; i_addr = 32'h8;
        @(negedge clock);                 // cycle 1
        @(negedge clock);                 // cycle 2
        total++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h1234) begin
            bad++; $display("FAIL held_ack: got ack=%b rdata=%h want 1 1234", i_ack, i_rdata);
        end
        @(negedge clock);                 // cycle 3: req still high, DONE did not grant
        total++;
        if (mem_req !== 1'b0 || (n_access - base) !== 1) begin
            bad++; $display("FAIL held_single: got mreq=%b accesses=%0d want 0 1", mem_req, n_access - base);
        end
        @(negedge clock);                 // cycle 4: second access after IDLE
        total++;
        if (mem_req !== 1'b1) begin
            bad++; $display("FAIL held_second: got mreq=%b want 1", mem_req);
        end
        i_req = 1'b0;                     // drop mid-access; ack still expected
        @(negedge clock);                 // cycle 5
        total++;
        if (i_ack !== 1'b1 || (n_access - base) !== 2) begin
            bad++; $display("FAIL held_drop_ack: got ack=%b accesses=%0d want 1 2", i_ack, n_access - base);
        end
    endtask

    task automatic test_watchdog();
        hang = 1'b1;
        @(negedge clock);                 // cycle 0
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            total++;
            if ({mem_req, d_ack, err, d_stall} !== 4'b1001) begin
                bad++; $display("FAIL wd_wait c%0d: got req,ack,err,stall=%b want 1001", c, {mem_req, d_ack, err, d_stall});
            end
        end
        @(negedge clock);                 // cycle 6
        total++;
        if ({d_ack, err, mem_req} !== 3'b110 || d_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL wd_abort: got ack,err,mreq=%b rdata=%h want 110 deadbeef", {d_ack, err, mem_req}, d_rdata);
        end
        d_req = 1'b0; hang = 1'b0;
        @(negedge clock);                 // cycle 7
        total++;
        if ({d_ack, err} !== 2'b00) begin
            bad++; $display("FAIL wd_pulse: got ack,err=%b want 00", {d_ack, err});
        end
    endtask

    task automatic test_reset_mid();
        hang = 1'b1;
        @(negedge clock);                 // cycle 0
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge clock);                 // cycle 1
        total++;
        if (mem_req !== 1'b1) begin
            bad++; $display("FAIL rst_mid_busy: got mreq=%b want 1", mem_req);
        end
        reset = 1'b1;
        @(negedge clock);                 // cycle 2
        total++;
        if ({mem_req, i_ack, err} !== 3'b000) begin
            bad++; $display("FAIL rst_mid_clear: got mreq,ack,err=%b want 000", {mem_req, i_ack, err});
        end
        reset = 1'b0; hang = 1'b0; rdata_cfg = 32'hABC;
        @(negedge clock);                 // cycle 3
        total++;
        if ({mem_req, i_ack} !== 2'b10 || mem_addr !== 32'h10) begin
            bad++; $display("FAIL rst_mid_reissue: got mreq,ack=%b addr=%h want 10 10", {mem_req, i_ack}, mem_addr);
        end
        @(negedge clock);                 // cycle 4
        total++;
        if (i_ack !== 1'b1 || i_rdata !== 32'hABC) begin
            bad++; $display("FAIL rst_mid_done: got ack=%b rdata=%h want 1 abc", i_ack, i_rdata);
        end
        i_req = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_fetch_alone();
        test_store_wait();
        test_collision();
        test_held_req();
        test_watchdog();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
